// File: rtl/eth_pkg.sv
// Shared constants, status bit positions and controller state encoding for the
// Ethernet receive-bank controller.
package eth_pkg;

    localparam int ETH_MINLEN = 60;
    localparam int ETH_MAXLEN = 1514;

    localparam int ST_GEN  = 0;
    localparam int ST_CRC  = 1;
    localparam int ST_RUNT = 2;
    localparam int ST_LONG = 3;

    typedef logic [3:0]  fr_stat_t;
    typedef logic [10:0] fr_len_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } ctrl_state_e;

    function automatic fr_stat_t frame_status(input fr_len_t len,
                                              input logic    gen,
                                              input logic    crc,
                                              input int      minlen,
                                              input int      maxlen);
        fr_stat_t st;
        st          = '0;
        st[ST_GEN]  = gen;
        st[ST_CRC]  = crc;
        st[ST_RUNT] = (int'(len) < minlen);
        st[ST_LONG] = (int'(len) > maxlen);
        return st;
    endfunction

endpackage

// File: rtl/eth_rxbank_ctrl_if.sv
// Receiver-side and host-side handshake bundle of the receive-bank controller.
// The controller connects through the master modport, its environment through slave.
interface eth_rxbank_ctrl_if
    import eth_pkg::*;
#(
    parameter int NBL = 1
);

    logic           rx_ena;
    logic           rx_done;
    logic [NBL-1:0] wr_bank;
    logic           rx_rdy;
    fr_len_t        rx_cntb;
    logic           rx_err_gen;
    logic           rx_err_crc;

    logic           fr_avail;
    logic [NBL-1:0] fr_bank;
    fr_len_t        fr_len;
    fr_stat_t       fr_stat;
    logic           host_ack;

    modport master (
        output rx_ena, rx_done, wr_bank, fr_avail, fr_bank, fr_len, fr_stat,
        input  rx_rdy, rx_cntb, rx_err_gen, rx_err_crc, host_ack
    );

    modport slave (
        input  rx_ena, rx_done, wr_bank, fr_avail, fr_bank, fr_len, fr_stat,
        output rx_rdy, rx_cntb, rx_err_gen, rx_err_crc, host_ack
    );

endinterface

// File: rtl/eth_rxbank_rec.sv
// Per-bank frame record file: length, status and full flag for each bank, with a
// write port (capture), a release port (host ack) and a read mux for the head bank.
module eth_rxbank_rec
    import eth_pkg::*;
#(
    parameter int NBL = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [NBL-1:0]        wr_idx,
    input  fr_len_t               wr_len,
    input  fr_stat_t              wr_stat,
    input  logic                  rel_en,
    input  logic [NBL-1:0]        rel_idx,
    input  logic [NBL-1:0]        rd_idx,
    output fr_len_t               rd_len,
    output fr_stat_t              rd_stat,
    output logic                  rd_full,
    output logic [(1<<NBL)-1:0]   full_vec
);
    localparam int NB = 1 << NBL;

    fr_len_t        len_q  [NB];
    fr_len_t        len_d  [NB];
    fr_stat_t       stat_q [NB];
    fr_stat_t       stat_d [NB];
    logic [NB-1:0]  full_q;
    logic [NB-1:0]  full_d;

    // Write and release never target the same bank: the write bank is only armed while free.
    always_comb begin
        len_d  = len_q;
        stat_d = stat_q;
        full_d = full_q;
        if (wr_en) begin
            len_d[wr_idx]  = wr_len;
            stat_d[wr_idx] = wr_stat;
            full_d[wr_idx] = 1'b1;
        end
        if (rel_en) begin
            full_d[rel_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NB; i++) begin
                len_q[i]  <= '0;
                stat_q[i] <= '0;
            end
            full_q <= '0;
        end else begin
            len_q  <= len_d;
            stat_q <= stat_d;
            full_q <= full_d;
        end
    end

    assign rd_len   = len_q[rd_idx];
    assign rd_stat  = stat_q[rd_idx];
    assign rd_full  = full_q[rd_idx];
    assign full_vec = full_q;

endmodule

// File: rtl/eth_rxbank_ctrl.sv
// Ethernet receive sequencer over a round-robin multi-bank buffer: arms the receiver
// when a bank is free, captures length/status, and queues good frames for the host.
module eth_rxbank_ctrl
    import eth_pkg::*;
#(
    parameter int NBL    = 1,
    parameter int MINLEN = ETH_MINLEN,
    parameter int MAXLEN = ETH_MAXLEN
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               host_ena,
    input  logic               drop_bad,
    eth_rxbank_ctrl_if.master  bus,
    output logic [7:0]         drop_cnt,
    output logic [NBL:0]       busy_cnt
);
    localparam int NB = 1 << NBL;

    ctrl_state_e     state_q, state_d;
    logic [NBL-1:0]  wr_bank_q, wr_bank_d;
    logic [NBL-1:0]  head_q, head_d;
    logic [7:0]      drop_q, drop_d;
    logic [NBL:0]    busy_q, busy_d;

    logic            rx_ena;
    logic            rx_done;
    logic            rec_wr;
    logic            ack_take;
    fr_stat_t        cap_stat;
    logic [NB-1:0]   full_vec;
    logic            rd_full;
    fr_len_t         rd_len;
    fr_stat_t        rd_stat;

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        drop_d    = drop_q;
        rx_ena    = 1'b0;
        rx_done   = 1'b0;
        rec_wr    = 1'b0;
        cap_stat  = frame_status(bus.rx_cntb, bus.rx_err_gen, bus.rx_err_crc, MINLEN, MAXLEN);

        unique case (state_q)
            IDLE: begin
                if (host_ena && !full_vec[wr_bank_q]) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // The receiver only samples rx_ena while idle, so dropping it mid-frame is safe.
                rx_ena = host_ena;
                if (bus.rx_rdy) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (drop_bad && (|cap_stat)) begin
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end else begin
                    rec_wr    = 1'b1;
                    wr_bank_d = wr_bank_q + NBL'(1);
                end
                state_d = DONE;
            end
            DONE: begin
                rx_done = 1'b1;
                if (!bus.rx_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_take = bus.host_ack & rd_full;
        head_d   = ack_take ? head_q + NBL'(1) : head_q;
        busy_d   = busy_q;
        unique case ({rec_wr, ack_take})
            2'b10:   busy_d = busy_q + (NBL+1)'(1);
            2'b01:   busy_d = busy_q - (NBL+1)'(1);
            default: busy_d = busy_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            wr_bank_q <= '0;
            head_q    <= '0;
            drop_q    <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            head_q    <= head_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
        end
    end

    eth_rxbank_rec #(
        .NBL (NBL)
    ) u_rec (
        .clk      (clk),
        .clr      (clr),
        .wr_en    (rec_wr),
        .wr_idx   (wr_bank_q),
        .wr_len   (bus.rx_cntb),
        .wr_stat  (cap_stat),
        .rel_en   (ack_take),
        .rel_idx  (head_q),
        .rd_idx   (head_q),
        .rd_len   (rd_len),
        .rd_stat  (rd_stat),
        .rd_full  (rd_full),
        .full_vec (full_vec)
    );

    assign bus.rx_ena   = rx_ena;
    assign bus.rx_done  = rx_done;
    assign bus.wr_bank  = wr_bank_q;
    assign bus.fr_avail = rd_full;
    assign bus.fr_bank  = head_q;
    assign bus.fr_len   = rd_len;
    assign bus.fr_stat  = rd_stat;
    assign drop_cnt     = drop_q;
    assign busy_cnt     = busy_q;

endmodule
